// File: rtl/dot_product_pkg.sv
// Shared definitions for the streaming dot-product engine.
// Contents:
//   - default parameter values (element width, lanes per beat, max length)
//   - FSM state encoding
//   - helper computing the overflow-free accumulator/result width
package dot_product_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LANES      = 2;
  localparam int DEF_MAX_LEN    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Full product width plus enough headroom to sum max_len products.
  function automatic int calc_result_width(input int data_width, input int max_len);
    return 2 * data_width + $clog2(max_len);
  endfunction

endpackage

// File: rtl/dot_product_if.sv
// Operand/result bus of the dot-product engine.
// Signals:
//   cfg_len, cfg_signed   vector configuration, sampled on a vector's first beat
//   in_valid/in_ready     input beat handshake, in_a/in_b carry LANES packed elements
//   out_valid/out_ready   result handshake, out_result held until accepted
// Modports: master = operand source / result sink, slave = engine.
interface dot_product_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int LANES        = 2,
  parameter int LEN_WIDTH    = 5,
  parameter int RESULT_WIDTH = 20
);

  logic [LEN_WIDTH-1:0]          cfg_len;
  logic                          cfg_signed;
  logic                          in_valid;
  logic                          in_ready;
  logic [LANES*DATA_WIDTH-1:0]   in_a;
  logic [LANES*DATA_WIDTH-1:0]   in_b;
  logic                          out_valid;
  logic                          out_ready;
  logic [RESULT_WIDTH-1:0]       out_result;

  modport master (
    output cfg_len, cfg_signed, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  cfg_len, cfg_signed, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result
  );

endinterface

// File: rtl/dot_product_lane_mul.sv
// One lane of the dot-product engine: registered, masked multiply.
// Ports:
//   clk, rst_n  clock / synchronous active-low reset
//   load_i      capture a new product (beat accepted)
//   keep_i      lane carries a real element; 0 forces a zero contribution
//   signed_i    treat operands as two's complement
//   a_i, b_i    operand elements
//   prod_o      product extended to RESULT_WIDTH (registered)
module dot_product_lane_mul #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic                    keep_i,
  input  logic                    signed_i,
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  output logic [RESULT_WIDTH-1:0] prod_o
);

  logic [RESULT_WIDTH-1:0] a_ext_s;
  logic [RESULT_WIDTH-1:0] b_ext_s;
  logic [RESULT_WIDTH-1:0] prod_s;
  logic [RESULT_WIDTH-1:0] prod_q;
  logic [RESULT_WIDTH-1:0] prod_d;

  // Operand extension; multiplying the extended operands modulo 2^RESULT_WIDTH
  // yields the correctly extended full-width product in both modes.
  always_comb begin
    if (signed_i) begin
      a_ext_s = {{(RESULT_WIDTH-DATA_WIDTH){a_i[DATA_WIDTH-1]}}, a_i};
      b_ext_s = {{(RESULT_WIDTH-DATA_WIDTH){b_i[DATA_WIDTH-1]}}, b_i};
    end else begin
      a_ext_s = {{(RESULT_WIDTH-DATA_WIDTH){1'b0}}, a_i};
      b_ext_s = {{(RESULT_WIDTH-DATA_WIDTH){1'b0}}, b_i};
    end
    prod_s = a_ext_s * b_ext_s;
  end

  // Next product value: masked lanes contribute zero.
  always_comb begin
    prod_d = prod_q;
    if (load_i) begin
      if (keep_i) begin
        prod_d = prod_s;
      end else begin
        prod_d = '0;
      end
    end else begin
      prod_d = prod_q;
    end
  end

  // Product register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/dot_product_engine.sv
// Streaming multi-lane dot-product engine.
// Consumes LANES element pairs per accepted beat, accumulates one vector of
// run-time length, then presents the result until the sink accepts it.
// Ports:
//   clk, rst_n  clock / synchronous active-low reset
//   bus         dot_product_if slave: cfg, input beats, result handshake
//   busy        a vector is in flight (FSM not idle)
// Pipeline: lane products registered (stage 1), lane sum added into the
// accumulator (stage 2), accumulator copied to the output register.
module dot_product_engine
  import dot_product_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int LANES        = DEF_LANES,
  parameter int MAX_LEN      = DEF_MAX_LEN,
  parameter int LEN_WIDTH    = $clog2(MAX_LEN + 1),
  parameter int RESULT_WIDTH = calc_result_width(DATA_WIDTH, MAX_LEN)
) (
  input  logic         clk,
  input  logic         rst_n,
  dot_product_if.slave bus,
  output logic         busy
);

  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;        // elements still to consume
  logic                    signed_q, signed_d;  // mode latched on first beat
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_first_q, s1_first_d;
  logic                    s1_last_q, s1_last_d;
  logic                    s2_last_q, s2_last_d;
  logic [RESULT_WIDTH-1:0] acc_q, acc_d;
  logic                    out_valid_q, out_valid_d;
  logic [RESULT_WIDTH-1:0] out_result_q, out_result_d;

  logic                    in_ready_s;
  logic                    busy_s;
  logic                    beat_s;
  logic                    first_s;
  logic                    last_s;
  logic                    cur_signed_s;
  logic [LEN_WIDTH-1:0]    eff_len_s;
  logic [LEN_WIDTH-1:0]    cur_rem_s;
  logic [LANES-1:0]        lane_keep_s;
  logic [RESULT_WIDTH-1:0] lane_prod_s [LANES];
  logic [RESULT_WIDTH-1:0] lane_sum_s;

  // Beat qualification, length clamping and per-beat remaining count.
  always_comb begin
    beat_s  = bus.in_valid && in_ready_s;
    first_s = (state_q == ST_IDLE);
    if ((bus.cfg_len == '0) || (bus.cfg_len > LEN_WIDTH'(MAX_LEN))) begin
      eff_len_s = LEN_WIDTH'(MAX_LEN);
    end else begin
      eff_len_s = bus.cfg_len;
    end
    // Config only matters on the first beat; later beats use latched values.
    if (first_s) begin
      cur_rem_s    = eff_len_s;
      cur_signed_s = bus.cfg_signed;
    end else begin
      cur_rem_s    = rem_q;
      cur_signed_s = signed_q;
    end
    last_s = (cur_rem_s <= LEN_WIDTH'(LANES));
  end

  genvar l;
  generate
    for (l = 0; l < LANES; l++) begin : g_lane
      // Lanes at or beyond the remaining element count are padding.
      assign lane_keep_s[l] = (LEN_WIDTH'(l) < cur_rem_s);

      dot_product_lane_mul #(
        .DATA_WIDTH   (DATA_WIDTH),
        .RESULT_WIDTH (RESULT_WIDTH)
      ) u_lane_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (beat_s),
        .keep_i   (lane_keep_s[l]),
        .signed_i (cur_signed_s),
        .a_i      (bus.in_a[l*DATA_WIDTH +: DATA_WIDTH]),
        .b_i      (bus.in_b[l*DATA_WIDTH +: DATA_WIDTH]),
        .prod_o   (lane_prod_s[l])
      );
    end
  endgenerate

  // Adder tree over the registered lane products.
  always_comb begin
    lane_sum_s = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum_s = lane_sum_s + lane_prod_s[i];
    end
  end

  // Datapath next-state: counters, pipeline flags, accumulator, output.
  always_comb begin
    rem_d        = rem_q;
    signed_d     = signed_q;
    acc_d        = acc_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;

    if (beat_s) begin
      signed_d = cur_signed_s;
      if (last_s) begin
        rem_d = '0;
      end else begin
        rem_d = cur_rem_s - LEN_WIDTH'(LANES);
      end
    end else begin
      rem_d = rem_q;
    end

    s1_valid_d = beat_s;
    s1_first_d = beat_s && first_s;
    s1_last_d  = beat_s && last_s;
    s2_last_d  = s1_valid_q && s1_last_q;

    // First beat overwrites the accumulator, so no clear cycle is needed.
    if (s1_valid_q) begin
      if (s1_first_q) begin
        acc_d = lane_sum_s;
      end else begin
        acc_d = acc_q + lane_sum_s;
      end
    end else begin
      acc_d = acc_q;
    end

    if (s2_last_q) begin
      out_valid_d  = 1'b1;
      out_result_d = acc_q;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q        <= '0;
      signed_q     <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_first_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s2_last_q    <= 1'b0;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else begin
      rem_q        <= rem_d;
      signed_q     <= signed_d;
      s1_valid_q   <= s1_valid_d;
      s1_first_q   <= s1_first_d;
      s1_last_q    <= s1_last_d;
      s2_last_q    <= s2_last_d;
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
    end
  end

  // FSM next-state and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    in_ready_s = 1'b0;
    busy_s     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b0;
        if (beat_s) begin
          state_d = last_s ? ST_DRAIN : ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        in_ready_s = 1'b1;
        if (beat_s && last_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        // Leaves on the same edge that loads the output register.
        if (s2_last_q) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign busy           = busy_s;

endmodule

// File: tb/tb_dot_product_engine.sv
module tb_dot_product_engine;
  import dot_product_pkg::*;

  localparam int DW      = 8;
  localparam int LANES   = 2;
  localparam int MAX_LEN = 16;
  localparam int LW      = $clog2(MAX_LEN + 1);
  localparam int RW      = 2 * DW + $clog2(MAX_LEN);
  localparam int NBUF    = MAX_LEN + LANES;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   cyc = 0;

  always #5 clk = ~clk;

  // Cycle index: after the active edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  dot_product_if #(.DATA_WIDTH(DW), .LANES(LANES), .LEN_WIDTH(LW), .RESULT_WIDTH(RW)) bus ();

  dot_product_engine #(.DATA_WIDTH(DW), .LANES(LANES), .MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  int tests = 0;
  int fails = 0;
  logic [RW-1:0] sb_q[$];
  int last_acc_cyc = 0;
  int ready_mode = 1;            // 0: hold low, 1: hold high, 2: random
  logic [DW-1:0] va [NBUF];
  logic [DW-1:0] vb [NBUF];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference: plain arithmetic over the element arrays.
  function automatic logic [RW-1:0] model(input int len_cfg, input bit sgn);
    int n;
    longint s, ai, bi;
    n = (len_cfg == 0 || len_cfg > MAX_LEN) ? MAX_LEN : len_cfg;
    s = 0;
    for (int i = 0; i < n; i++) begin
      ai = sgn ? longint'($signed(va[i])) : longint'(va[i]);
      bi = sgn ? longint'($signed(vb[i])) : longint'(vb[i]);
      s += ai * bi;
    end
    return RW'(s);
  endfunction

  task automatic fill_random();
    for (int i = 0; i < NBUF; i++) begin
      va[i] = DW'($urandom);
      vb[i] = DW'($urandom);
    end
  endtask

  task automatic drive_beat(input int beat, input int len_cfg, input bit sgn, input bit first, output bit ok);
    logic [LANES*DW-1:0] pa, pb;
    for (int l = 0; l < LANES; l++) begin
      pa[l*DW +: DW] = va[beat*LANES + l];
      pb[l*DW +: DW] = vb[beat*LANES + l];
    end
    bus.in_a = pa;
    bus.in_b = pb;
    // Config is scrambled on later beats; the engine must ignore it.
    bus.cfg_len    = first ? LW'(len_cfg) : LW'($urandom);
    bus.cfg_signed = first ? sgn : 1'($urandom);
    bus.in_valid   = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL beat_accept_timeout actual=not accepted required=accepted beat=%0d", beat);
    end
  endtask

  task automatic send_vector(input int len_cfg, input bit sgn, input int gap_lo, input int gap_hi,
                             input bit use_exp, input logic [RW-1:0] exp_v);
    int n, beats;
    bit ok;
    n = (len_cfg == 0 || len_cfg > MAX_LEN) ? MAX_LEN : len_cfg;
    beats = (n + LANES - 1) / LANES;
    sb_q.push_back(use_exp ? exp_v : model(len_cfg, sgn));
    for (int k = 0; k < beats; k++) begin
      drive_beat(k, len_cfg, sgn, k == 0, ok);
      if (k == beats - 1) begin
        last_acc_cyc = cyc;
      end else begin
        repeat ($urandom_range(gap_lo, gap_hi)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout actual=%0d pending required=0 pending", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Sink-side ready generator.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on each output handshake.
  initial begin
    bit prev_valid, hs, hs_prev;
    logic [RW-1:0] prev_result, exp;
    prev_valid = 1'b0;
    hs_prev = 1'b0;
    prev_result = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        hs_prev = 1'b0;
      end else begin
        if (hs_prev) begin
          check("ready_after_handshake", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);
        end
        if (bus.out_valid) begin
          check("in_ready_low_while_valid", 64'(bus.in_ready), 64'd0);
          if (!prev_valid) begin
            check("out_latency", 64'(cyc - last_acc_cyc), 64'd2);
          end else begin
            check("result_stable", 64'(bus.out_result), 64'(prev_result));
          end
        end
        hs = bus.out_valid && bus.out_ready;
        if (hs) begin
          if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result actual=%0h required=no result", bus.out_result);
          end else begin
            exp = sb_q.pop_front();
            check("result", 64'(bus.out_result), 64'(exp));
          end
        end
        prev_valid = bus.out_valid;
        prev_result = bus.out_result;
        hs_prev = hs;
      end
    end
  end

  initial begin
    bit ok;
    int t;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.cfg_len = '0;
    bus.cfg_signed = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_out_result", 64'(bus.out_result), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic unsigned length-4 vector.
    fill_random();
    va[0] = 8'd1; va[1] = 8'd2; va[2] = 8'd3; va[3] = 8'd4;
    vb[0] = 8'd5; vb[1] = 8'd6; vb[2] = 8'd7; vb[3] = 8'd8;
    send_vector(4, 1'b0, 0, 0, 1'b1, RW'(70));
    check("busy_in_flight", 64'(busy), 64'd1);
    wait_drain();

    // Odd length: lane 1 of last beat is junk.
    va[0] = 8'd1; va[1] = 8'd2; va[2] = 8'd3; va[3] = 8'd99;
    vb[0] = 8'd1; vb[1] = 8'd1; vb[2] = 8'd1; vb[3] = 8'd99;
    send_vector(3, 1'b0, 0, 0, 1'b1, RW'(6));
    wait_drain();

    // Signed vs unsigned on the same data.
    va[0] = 8'hFF; va[1] = 8'h80;
    vb[0] = 8'h02; vb[1] = 8'h01;
    send_vector(2, 1'b1, 0, 0, 1'b1, RW'(-130));
    wait_drain();
    send_vector(2, 1'b0, 0, 0, 1'b1, RW'(638));
    wait_drain();

    // Bubbles and output backpressure.
    va[0] = 8'd1; va[1] = 8'd2; va[2] = 8'd3; va[3] = 8'd4;
    vb[0] = 8'd5; vb[1] = 8'd6; vb[2] = 8'd7; vb[3] = 8'd8;
    ready_mode = 0;
    send_vector(4, 1'b0, 3, 3, 1'b1, RW'(70));
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    check("held_out_valid", 64'(bus.out_valid), 64'd1);
    check("held_out_result", 64'(bus.out_result), 64'd70);
    check("held_in_ready", 64'(bus.in_ready), 64'd0);
    ready_mode = 1;
    wait_drain();

    // Boundary lengths clamp to MAX_LEN.
    for (int i = 0; i < NBUF; i++) begin
      va[i] = 8'hFF;
      vb[i] = 8'hFF;
    end
    send_vector(0, 1'b0, 0, 1, 1'b1, RW'(1040400));
    wait_drain();
    send_vector(MAX_LEN + 5, 1'b0, 0, 1, 1'b1, RW'(1040400));
    wait_drain();

    // Reset mid-vector discards partial state.
    fill_random();
    drive_beat(0, 4, 1'b0, 1'b1, ok);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_in_ready", 64'(bus.in_ready), 64'd1);
    va[0] = 8'd3; va[1] = 8'd4;
    vb[0] = 8'd5; vb[1] = 8'd6;
    send_vector(2, 1'b0, 0, 0, 1'b1, RW'(39));
    wait_drain();

    // Randomized vectors with random sink backpressure.
    ready_mode = 2;
    for (int v = 0; v < 40; v++) begin
      fill_random();
      send_vector(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 0, 2, 1'b0, '0);
    end
    ready_mode = 1;
    wait_drain();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dot_product_engine.md
Name: dot_product_engine

Overview:
- Streaming, multi-lane dot-product engine: the next generation of our single-lane, fixed-length dot-product unit.
- Consumes LANES element pairs per beat over a valid/ready handshake, with a run-time vector length and signed/unsigned mode.
- Presents one result per vector on a valid/ready output held until accepted.
- Sits between the dual operand memories' read ports and the result collector.

Parameters:
- DATA_WIDTH, 8, width of each operand element.
- LANES, 2, element pairs consumed per input beat (>=1).
- MAX_LEN, 16, maximum vector length in elements (>=LANES).
- LEN_WIDTH, $clog2(MAX_LEN+1), width of cfg_len.
- RESULT_WIDTH, 2*DATA_WIDTH+$clog2(MAX_LEN), accumulator/result width; no overflow possible.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cfg_len  in  LEN_WIDTH  vector length in elements; sampled on the first beat of each vector.
- cfg_signed  in  1  1 = two's-complement operands; sampled with cfg_len.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine accepts beat.
- in_a  in  LANES*DATA_WIDTH  operand A elements; lane 0 in LSBs = lowest element index.
- in_b  in  LANES*DATA_WIDTH  operand B elements, same packing.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_result  out  RESULT_WIDTH  dot product, sign-extended when signed.
- busy  out  1  vector in flight (state != IDLE).

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, element counter=0, accumulator=0, pipeline valids=0, out_valid=0, out_result=0, in_ready=1, busy=0. Reset mid-vector discards all partial data; a result held unaccepted is dropped.
- Beat accepted when in_valid && in_ready at a clk edge.
- Length rules, applied on the first beat: cfg_len==0 or cfg_len>MAX_LEN uses MAX_LEN. Beats per vector = ceil(len/LANES).
- Last-beat masking: on the final beat, lanes with index >= len - LANES*(beats-1) contribute 0 and their data is ignored.
- Products: per lane, full 2*DATA_WIDTH product. Signed or unsigned per the latched cfg_signed. Extended (sign or zero) to RESULT_WIDTH.
- Pipeline stage 1 registers the masked lane products and a last flag. Stage 2 sums the lanes and adds to the accumulator. The first beat's sum overwrites the accumulator, with no clear cycle needed.
- FSM states:
  - IDLE: in_ready=1. First beat -> ACCUM, or -> DRAIN if the vector is a single beat.
  - ACCUM: in_ready=1. Last beat accepted -> DRAIN.
  - DRAIN: in_ready=0, waiting for the pipeline to empty -> HOLD.
  - HOLD: out_valid=1, out_result stable. On out_valid && out_ready -> IDLE.
- Latency: the last beat is accepted at edge E; out_valid rises after edge E+2. With out_ready=1, the handshake occurs at edge E+3 and in_ready is 1 again after E+3.
- in_ready is 0 from the edge accepting the last beat until the output handshake completes. There is no overlap of consecutive vectors.
- in_valid gaps (bubbles) mid-vector are legal and do not alter the result.
- out_valid, once high, stays high with out_result constant until accepted. out_ready while out_valid=0 is ignored.
- cfg_len and cfg_signed changes after the first beat have no effect until the next vector.

Decomposition:
- Shared package dot_product_pkg:
  - state enum (IDLE, ACCUM, DRAIN, HOLD)
  - default DATA_WIDTH/LANES/MAX_LEN constants
  - function computing RESULT_WIDTH
- One sub-module dot_product_lane_mul: one lane's registered, masked, signed/unsigned multiply with extension to RESULT_WIDTH. Instantiated LANES times via generate.

Test Plan:
- Unsigned, LANES=2, cfg_len=4, a={1,2,3,4}, b={5,6,7,8}, 2 back-to-back beats, out_ready=1 -> out_result=70, out_valid rises 2 cycles after last beat, high for 1 cycle.
- Odd length masking: cfg_len=3, a={1,2,3,99}, b={1,1,1,99} -> out_result=6; lane 1 of the last beat ignored.
- Signed: cfg_signed=1, cfg_len=2, a={0xFF,0x80}, b={0x02,0x01} -> out_result = -2 + -128 = -130 (sign-extended RESULT_WIDTH value); the same data unsigned gives 510+128=638.
- Backpressure and bubbles: cfg_len=4 with in_valid low for 3 cycles between beats, and out_ready low for 5 cycles -> out_valid held with stable 70, in_ready=0 throughout, next vector accepted only the cycle after the handshake.
- Boundary lengths: cfg_len=0 and cfg_len=MAX_LEN+5 with all elements 0xFF unsigned -> both take MAX_LEN elements, result=16*65025=1040400 (fits in 20 bits).
- Reset mid-vector: 1 of 2 beats accepted, then rst_n=0 for 1 cycle -> out_valid=0, busy=0, in_ready=1. A following cfg_len=2 vector {3,4}·{5,6} gives 39 with no carry-over.
